// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator family: mode encodings,
// colour-bar lookup and frame geometry helper.
package vga_pkg;

    localparam logic [1:0] MODE_DIAMOND_SHR = 2'd0;
    localparam logic [1:0] MODE_DIAMOND_SHL = 2'd1;
    localparam logic [1:0] MODE_BARS        = 2'd2;
    localparam logic [1:0] MODE_GRID        = 2'd3;

    // {r,g,b} on/off per bar; index 0 is the leftmost bar
    localparam logic [0:7][2:0] BAR_RGB = {
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic int frame_total(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with active/sync decode and end-of-frame strobe.
// Outputs are combinational from the registered h/v state.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [10:0] h,
    output logic [9:0]  v,
    output logic        active,
    output logic        hs,
    output logic        vs,
    output logic        eof
);

    localparam int H_TOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    logic h_wrap;
    assign h_wrap = (h == H_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_wrap ? 11'd0 : h + 11'd1;
            if (h_wrap)
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
    end

    assign active = (h < 11'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    assign hs     = (h >= 11'(H_ACTIVE + H_FP)) && (h < 11'(H_ACTIVE + H_FP + H_SYNC));
    // vs spans whole lines because v only moves on the h wrap
    assign vs     = (v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign eof    = h_wrap && (v == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster timing, debounced mode button and four
// patterns; all outputs registered one clock after the h/v state.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit SYNC_POL        = 1'b0,
    parameter int COLOR_BITS      = 1,
    parameter int CX              = 320,
    parameter int CY              = 240,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  button,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic [10:0]           x,
    output logic [9:0]            y,
    output logic [11:0]           frame,
    output logic [1:0]            mode
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [10:0] h;
    logic [9:0]  v;
    logic        active, hs, vs, eof;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock (clock),
        .reset (reset),
        .h     (h),
        .v     (v),
        .active(active),
        .hs    (hs),
        .vs    (vs),
        .eof   (eof)
    );

    logic            btn_meta, btn_sync, btn_db, btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      pending, mode_cur;
    logic [11:0]     frame_cnt;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    // A press landing on the eof edge bumps pending after mode has already sampled it.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_db    <= 1'b0;
            btn_db_q  <= 1'b0;
            db_cnt    <= '0;
            pending   <= MODE_DIAMOND_SHR;
            mode_cur  <= MODE_DIAMOND_SHR;
            frame_cnt <= '0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            btn_db_q <= btn_db;
            if (btn_db && !btn_db_q)
                pending <= pending + 2'd1;
            if (eof) begin
                frame_cnt <= frame_cnt + 12'd1;
                mode_cur  <= pending;
            end
        end
    end

    logic [11:0]           hx, vx, dx, dy, dm;
    logic [15:0]           d_base, d;
    logic [3:0]            sh_r, sh_g, sh_b;
    logic [2:0]            bar, bar_rgb;
    logic                  grid;
    logic [COLOR_BITS-1:0] r_nx, g_nx, b_nx;

    always_comb begin
        hx = {1'b0, h};
        vx = {2'b00, v};
        dx = (hx >= 12'(CX)) ? hx - 12'(CX) : 12'(CX) - hx;
        dy = (vx >= 12'(CY)) ? vx - 12'(CY) : 12'(CY) - vx;
        dm = dx + dy;
        if (mode_cur == MODE_DIAMOND_SHR)
            d_base = 16'(dm >> dm[4:3]);
        else
            d_base = {4'b0000, dm} << dm[6:5];
        d = d_base - {4'b0000, frame_cnt};
        // Frame bits 8..10 slowly slide the channel windows up one bit
        sh_r = 4'd7 + 4'(frame_cnt[8]);
        sh_g = 4'd6 + 4'(frame_cnt[9]);
        sh_b = 4'd5 + 4'(frame_cnt[10]);

        // bar = floor(h*8/H_ACTIVE) by comparing h*8 against k*H_ACTIVE
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if ({h, 3'b000} >= 14'(k * H_ACTIVE))
                bar = 3'(k);
        bar_rgb = BAR_RGB[bar];
        grid    = (h[4:0] == 5'd0) || (v[4:0] == 5'd0);

        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        case (mode_cur)
            MODE_DIAMOND_SHR, MODE_DIAMOND_SHL: begin
                r_nx = COLOR_BITS'(d >> sh_r);
                g_nx = COLOR_BITS'(d >> sh_g);
                b_nx = COLOR_BITS'(d >> sh_b);
            end
            MODE_BARS: begin
                r_nx = {COLOR_BITS{bar_rgb[2]}};
                g_nx = {COLOR_BITS{bar_rgb[1]}};
                b_nx = {COLOR_BITS{bar_rgb[0]}};
            end
            MODE_GRID: begin
                r_nx = {COLOR_BITS{grid}};
                g_nx = {COLOR_BITS{grid}};
                b_nx = {COLOR_BITS{grid}};
            end
        endcase
        if (!active) begin
            r_nx = '0;
            g_nx = '0;
            b_nx = '0;
        end
    end

    // frame/mode are delayed with the pixel so they change on pixel (0,0)
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
            x     <= '0;
            y     <= '0;
            frame <= '0;
            mode  <= MODE_DIAMOND_SHR;
        end else begin
            hsync <= hs ? SYNC_POL : ~SYNC_POL;
            vsync <= vs ? SYNC_POL : ~SYNC_POL;
            de    <= active;
            r     <= r_nx;
            g     <= g_nx;
            b     <= b_nx;
            x     <= h;
            y     <= v;
            frame <= frame_cnt;
            mode  <= mode_cur;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench: a tiny-raster instance for timing, reset and button behaviour, and a
// 640-wide instance for diamond arithmetic and colour bars.
module tb_vga_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Small raster: H 8/2/2/2 (14 clocks), V 4/1/1/1 (7 lines), 98 clocks/frame
    logic        rst_s, btn_s, hs_s, vs_s, de_s;
    logic [3:0]  r_s, g_s, b_s;
    logic [10:0] x_s;
    logic [9:0]  y_s;
    logic [11:0] fr_s;
    logic [1:0]  md_s;

    vga_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .COLOR_BITS(4), .CX(3), .CY(2), .DEBOUNCE_CYCLES(4)
    ) u_small (
        .clock(clk), .reset(rst_s), .button(btn_s),
        .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .r(r_s), .g(g_s), .b(b_s), .x(x_s), .y(y_s),
        .frame(fr_s), .mode(md_s)
    );

    // Wide raster: 800 clocks/line, V 8/1/1/1 (11 lines), 8800 clocks/frame
    logic        rst_m, btn_m, hs_m, vs_m, de_m;
    logic [3:0]  r_m, g_m, b_m;
    logic [10:0] x_m;
    logic [9:0]  y_m;
    logic [11:0] fr_m;
    logic [1:0]  md_m;

    vga_pattern_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .COLOR_BITS(4), .CX(320), .CY(4), .DEBOUNCE_CYCLES(4)
    ) u_mid (
        .clock(clk), .reset(rst_m), .button(btn_m),
        .hsync(hs_m), .vsync(vs_m), .de(de_m),
        .r(r_m), .g(g_m), .b(b_m), .x(x_m), .y(y_m),
        .frame(fr_m), .mode(md_m)
    );

    typedef struct {
        int cyc;
        int de, hs, vs, x, y, frame;
    } tvec_t;

    typedef struct {
        int x;
        int r, g, b, de;
    } bvec_t;

    tvec_t tv[14];
    bvec_t bv[12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_s(input int n);
        rst_s = 1'b1;
        repeat (n) step();
        rst_s = 1'b0;
    endtask

    // Entry: sampled just after the reset edge (k = 0)
    task automatic run_table(input string tag);
        int k;
        k = 0;
        foreach (tv[i]) begin
            while (k < tv[i].cyc) begin
                step();
                k++;
            end
            chk($sformatf("%s k=%0d de", tag, k), de_s, tv[i].de);
            chk($sformatf("%s k=%0d hsync", tag, k), hs_s, tv[i].hs);
            chk($sformatf("%s k=%0d vsync", tag, k), vs_s, tv[i].vs);
            chk($sformatf("%s k=%0d frame", tag, k), fr_s, tv[i].frame);
            if (tv[i].de == 1 || k == 0) begin
                chk($sformatf("%s k=%0d x", tag, k), x_s, tv[i].x);
                chk($sformatf("%s k=%0d y", tag, k), y_s, tv[i].y);
            end
        end
    endtask

    // Mode-0 reference for the wide instance; n = pixel index since reset
    function automatic void model_m(input int n, output int er, output int eg,
                                    output int eb, output int ede, output int ehs,
                                    output int evs);
        int hh, vv, f, dxx, dyy, dmm, sh, dd;
        hh  = n % 800;
        vv  = (n / 800) % 11;
        f   = n / 8800;
        ede = (hh < 640 && vv < 8) ? 1 : 0;
        ehs = (hh >= 656 && hh < 752) ? 1 : 0;
        evs = (vv == 9) ? 1 : 0;
        dxx = (hh > 320) ? hh - 320 : 320 - hh;
        dyy = (vv > 4) ? vv - 4 : 4 - vv;
        dmm = dxx + dyy;
        sh  = (dmm / 8) % 4;
        dd  = ((dmm / (1 << sh)) - f) & 32'hFFFF;
        er  = ede ? (dd >> (7 + (f / 256) % 2)) & 15 : 0;
        eg  = ede ? (dd >> (6 + (f / 512) % 2)) & 15 : 0;
        eb  = ede ? (dd >> (5 + (f / 1024) % 2)) & 15 : 0;
    endfunction

    initial begin
        int c_hs, c_vs, c_de, bad_f, k;
        int er, eg, eb, ede, ehs, evs;

        //         cyc  de hs vs  x  y  fr
        tv[0]  = '{  0, 0, 1, 1, 0, 0, 0};
        tv[1]  = '{  1, 1, 1, 1, 0, 0, 0};
        tv[2]  = '{  8, 1, 1, 1, 7, 0, 0};
        tv[3]  = '{  9, 0, 1, 1, 0, 0, 0};
        tv[4]  = '{ 11, 0, 0, 1, 0, 0, 0};
        tv[5]  = '{ 12, 0, 0, 1, 0, 0, 0};
        tv[6]  = '{ 13, 0, 1, 1, 0, 0, 0};
        tv[7]  = '{ 15, 1, 1, 1, 0, 1, 0};
        tv[8]  = '{ 60, 0, 1, 1, 0, 0, 0};
        tv[9]  = '{ 71, 0, 1, 0, 0, 0, 0};
        tv[10] = '{ 82, 0, 0, 0, 0, 0, 0};
        tv[11] = '{ 85, 0, 1, 1, 0, 0, 0};
        tv[12] = '{ 98, 0, 1, 1, 0, 0, 0};
        tv[13] = '{ 99, 1, 1, 1, 0, 0, 1};

        //           x    r   g   b  de
        bv[0]  = '{  0, 15, 15, 15, 1};
        bv[1]  = '{ 79, 15, 15, 15, 1};
        bv[2]  = '{ 80, 15, 15,  0, 1};
        bv[3]  = '{159, 15, 15,  0, 1};
        bv[4]  = '{160,  0, 15, 15, 1};
        bv[5]  = '{240,  0, 15,  0, 1};
        bv[6]  = '{320, 15,  0, 15, 1};
        bv[7]  = '{400, 15,  0,  0, 1};
        bv[8]  = '{559,  0,  0, 15, 1};
        bv[9]  = '{560,  0,  0,  0, 1};
        bv[10] = '{639,  0,  0,  0, 1};
        bv[11] = '{640,  0,  0,  0, 0};

        btn_s = 1'b0;
        btn_m = 1'b0;
        rst_m = 1'b1;
        rst_s = 1'b1;

        // Reset state and first-frame timing spot checks
        reset_s(3);
        chk("reset mode", md_s, 0);
        run_table("timing");

        // Mid-frame reset at h=5, v=2, then the same sequence again
        reset_s(1);
        repeat (33) step();
        chk("pre-reset x", x_s, 4);
        chk("pre-reset y", y_s, 2);
        reset_s(1);
        chk("midreset mode", md_s, 0);
        run_table("midreset");

        // Two frames of sync/de counts, with a bouncing press in frame 0
        reset_s(1);
        c_hs = 0; c_vs = 0; c_de = 0;
        for (int kk = 1; kk <= 196; kk++) begin
            btn_s = (kk >= 3 && kk <= 14) ? (((kk - 3) / 2) % 2 == 0)
                                          : (kk >= 15 && kk <= 24);
            step();
            if (hs_s == 1'b0) c_hs++;
            if (vs_s == 1'b0) c_vs++;
            if (de_s == 1'b1) c_de++;
            if (kk == 98) chk("bounce mode before eof", md_s, 0);
            if (kk == 99) chk("bounce mode after eof", md_s, 1);
        end
        btn_s = 1'b0;
        chk("hsync low clocks", c_hs, 28);
        chk("vsync low clocks", c_vs, 28);
        chk("de high clocks", c_de, 64);
        step();
        chk("frame after 2 frames", fr_s, 2);
        chk("mode single increment", md_s, 1);

        // Three presses in frame 0, fourth lands on the frame-1 eof edge
        reset_s(1);
        for (int kk = 1; kk <= 295; kk++) begin
            k = kk - 1;
            btn_s = (k >= 2 && k < 10) || (k >= 18 && k < 26) ||
                    (k >= 34 && k < 42) || (k >= 189);
            step();
            if (kk == 98) chk("3press mode before eof", md_s, 0);
            if (kk == 99) begin
                chk("3press mode after eof", md_s, 3);
                chk("grid (0,0) r", r_s, 15);
                chk("grid (0,0) b", b_s, 15);
            end
            if (kk == 102) chk("grid (3,0) g", g_s, 15);
            if (kk == 115) begin
                chk("grid (2,1) r", r_s, 0);
                chk("grid (2,1) b", b_s, 0);
            end
            if (kk == 197) chk("eof-cycle press deferred", md_s, 3);
            if (kk == 295) chk("fourth press wraps", md_s, 0);
        end
        btn_s = 1'b0;

        // Wide instance: reset values with active-high sync
        rst_m = 1'b1;
        step();
        rst_m = 1'b0;
        chk("mid reset hsync", hs_m, 0);
        chk("mid reset vsync", vs_m, 0);
        chk("mid reset de", de_m, 0);
        chk("mid reset r", r_m, 0);
        chk("mid reset frame", fr_m, 0);

        // Frames 0..2 against the mode-0 model; presses set mode 1 then 2
        bad_f = 0;
        for (int kk = 1; kk <= 35200; kk++) begin
            k = kk - 1;
            btn_m = (k >= 20000 && k < 20008) || (k >= 30000 && k < 30008);
            step();
            if (k < 26400) begin
                model_m(k, er, eg, eb, ede, ehs, evs);
                if (de_m != ede[0] || hs_m != ehs[0] || vs_m != evs[0] ||
                    r_m != er[3:0] || g_m != eg[3:0] || b_m != eb[3:0])
                    bad_f++;
                if (k % 8800 == 8799) begin
                    chk($sformatf("mode0 frame %0d bad pixels", k / 8800), bad_f, 0);
                    bad_f = 0;
                end
            end
            if (kk == 1) begin
                chk("shr (0,0) r", r_m, 2);
                chk("shr (0,0) g", g_m, 5);
                chk("shr (0,0) b", b_m, 10);
            end
            if (kk == 3521) begin
                chk("centre x", x_m, 320);
                chk("centre y", y_m, 4);
                chk("centre r", r_m, 0);
            end
            if (kk == 12321) chk("centre f1 r", r_m, 15);
            if (kk == 26401) begin
                chk("shl mode", md_m, 1);
                chk("shl frame", fr_m, 3);
                chk("shl (0,0) r", r_m, 10);
                chk("shl (0,0) g", g_m, 4);
                chk("shl (0,0) b", b_m, 8);
            end
        end
        btn_m = 1'b0;

        // Colour bars on line 0 of frame 4
        k = 35200;
        foreach (bv[i]) begin
            while (k < 35201 + bv[i].x) begin
                step();
                k++;
            end
            if (i == 0) chk("bars mode", md_m, 2);
            chk($sformatf("bar x=%0d r", bv[i].x), r_m, bv[i].r);
            chk($sformatf("bar x=%0d g", bv[i].x), g_m, bv[i].g);
            chk($sformatf("bar x=%0d b", bv[i].x), b_m, bv[i].b);
            chk($sformatf("bar x=%0d de", bv[i].x), de_m, bv[i].de);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
